// File: rtl/shift_right_add_inv.sv
`default_nettype none
// ============================================================================
// Module   : shift_right_add_inv
// Purpose  : Iterative inverse of the shift-right-add scaler. Given a signed
//            operand x it produces y with y + (y >>> SHIFT) ~= x, using the
//            fixed-point iteration y(k+1) = x - (y(k) >>> SHIFT), which
//            contracts by 2^-SHIFT per step. One operand is processed at a
//            time behind valid/ready handshakes on both sides.
//
// Parameters:
//   SHIFT     arithmetic right-shift amount, 1..31
//   ITER      maximum number of iteration updates per operand, >= 1
//
// Ports:
//   clk        in   1   clock, all state updates on the rising edge
//   rst        in   1   synchronous, active-high reset
//   in_valid   in   1   operand valid
//   in_ready   out  1   operand accepted when high (IDLE only)
//   data_i     in   32  signed operand x
//   out_valid  out  1   result valid (DONE only)
//   out_ready  in   1   downstream accepts the result
//   data_o     out  32  signed result y, registered
//   conv_o     out  1   last update left y unchanged, registered
//
// Build option:
//   SHIFT_RIGHT_ADD_INV_EARLY_EXIT_EN
//     When defined, a BUSY update that leaves y unchanged finishes the
//     operand immediately. When undefined, exactly ITER updates are always
//     performed and the latency is fixed at ITER+1 cycles.
//
// Revision : 1.0  initial release
// ============================================================================
module shift_right_add_inv #(
  parameter int SHIFT = 4,
  parameter int ITER  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] data_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] data_o,
  output logic               conv_o
);

  // Counter only needs to reach ITER-1; keep at least one bit.
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_q,     state_d;
  logic signed [31:0]   x_q,         x_d;
  logic signed [31:0]   y_q,         y_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic                 conv_q,      conv_d;
  logic signed [31:0]   res_q,       res_d;
  logic                 in_ready_q,  in_ready_d;
  logic                 out_valid_q, out_valid_d;

  logic signed [31:0]   y_next;
  logic                 y_same;
  logic                 finish;

  // One iteration step. Plain 32-bit two's-complement arithmetic, so any
  // overflow wraps; >>> floors, so negative values round toward -inf.
  assign y_next = x_q - (y_q >>> SHIFT);
  assign y_same = (y_next == y_q);

`ifdef SHIFT_RIGHT_ADD_INV_EARLY_EXIT_EN
  assign finish = (cnt_q == CNT_LAST) || y_same;
`else
  assign finish = (cnt_q == CNT_LAST);
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    conv_d  = conv_q;
    res_d   = res_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d     = data_i;
          y_d     = data_i;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        y_d    = y_next;
        cnt_d  = cnt_q + 1'b1;
        conv_d = y_same;
        if (finish) begin
          // The result register is loaded only on completion so data_o
          // keeps the previous result while the next operand iterates.
          res_d   = y_next;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake outputs are registered from the next state so they line up
    // exactly with the state register.
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      cnt_q       <= '0;
      conv_q      <= 1'b0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cnt_q       <= cnt_d;
      conv_q      <= conv_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_o    = res_q;
  assign conv_o    = conv_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_right_add_inv.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_right_add_inv
// Purpose  : Self-checking bench for shift_right_add_inv (SHIFT=4, ITER=8).
//            Expected results come from an arithmetic reference model using
//            floor division on 64-bit integers, plus fixed directed values.
// Revision : 1.0  initial release
// ============================================================================
module tb_shift_right_add_inv;

  localparam int SHIFT = 4;
  localparam int ITER  = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] data_i;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] data_o;
  logic               conv_o;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  shift_right_add_inv #(.SHIFT(SHIFT), .ITER(ITER)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_i    (data_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_o    (data_o),
    .conv_o    (conv_o)
  );

  // Reference: y <- x - floor(y / 2^SHIFT), wrapped to 32 bits.
  // n is the number of updates performed; latency is n+1.
  function automatic void model(input logic signed [31:0] x,
                                output logic signed [31:0] y,
                                output logic cv, output int n);
    longint xv, yv, prev, d, q, t;
    logic signed [31:0] w;
    xv = longint'(x);
    yv = xv;
    d  = longint'(1) << SHIFT;
    cv = 1'b0;
    n  = 0;
    for (int k = 0; k < ITER; k++) begin
      prev = yv;
      q = yv / d;
      if (yv < 0 && (yv % d) != 0) q = q - 1;
      t  = xv - q;
      w  = t[31:0];
      yv = longint'(w);
      n++;
      cv = (yv == prev);
`ifdef SHIFT_RIGHT_ADD_INV_EARLY_EXIT_EN
      if (cv) break;
`endif
    end
    w = yv[31:0];
    y = w;
  endfunction

  // Present x in IDLE, then count cycles after the accept edge until
  // out_valid is seen (lat = N means out_valid in cycle T+N). Bounded.
  task automatic run_op(input logic signed [31:0] x, output int lat);
    in_valid = 1'b1;
    data_i   = x;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    data_i   = $urandom;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      in_valid = $urandom_range(0, 1);
      @(negedge clk);
      lat++;
    end
  endtask

  // Complete the output handshake and return in IDLE at a negedge.
  task automatic finish_op();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else n_pass++;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else n_pass++;
    n_total++;
    if (data_o !== 32'sd0) $display("FAIL reset_data_o: got %0d expected 0", data_o);
    else n_pass++;
    n_total++;
    if (conv_o !== 1'b0) $display("FAIL reset_conv_o: got %b expected 0", conv_o);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic signed [31:0] xs  [3];
    logic signed [31:0] ys  [3];
    int                 lts [3];
    int lat;
    xs[0] = 32'sd17;  xs[1] = -32'sd17; xs[2] = 32'sd0;
    ys[0] = 32'sd16;  ys[1] = -32'sd16; ys[2] = 32'sd0;
`ifdef SHIFT_RIGHT_ADD_INV_EARLY_EXIT_EN
    lts[0] = 3; lts[1] = 4; lts[2] = 2;
`else
    lts[0] = ITER + 1; lts[1] = ITER + 1; lts[2] = ITER + 1;
`endif
    for (int i = 0; i < 3; i++) begin
      run_op(xs[i], lat);
      n_total++;
      if (lat !== lts[i]) $display("FAIL dir_latency x=%0d: got %0d expected %0d", xs[i], lat, lts[i]);
      else n_pass++;
      n_total++;
      if (data_o !== ys[i]) $display("FAIL dir_data x=%0d: got %0d expected %0d", xs[i], data_o, ys[i]);
      else n_pass++;
      n_total++;
      if (conv_o !== 1'b1) $display("FAIL dir_conv x=%0d: got %b expected 1", xs[i], conv_o);
      else n_pass++;
      finish_op();
      n_total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
        $display("FAIL dir_idle_after_hs: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic signed [31:0] x, ey;
    logic ec;
    int n, lat, hold;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) x = $urandom;
      else x = 32'(int'($urandom_range(0, 4000)) - 2000);
      hold = $urandom_range(0, 3);
      model(x, ey, ec, n);
      run_op(x, lat);
      n_total++;
      if (lat !== n + 1) $display("FAIL rnd_latency x=%0d: got %0d expected %0d", x, lat, n + 1);
      else n_pass++;
      n_total++;
      if (data_o !== ey) $display("FAIL rnd_data x=%0d: got %0d expected %0d", x, data_o, ey);
      else n_pass++;
      n_total++;
      if (conv_o !== ec) $display("FAIL rnd_conv x=%0d: got %b expected %b", x, conv_o, ec);
      else n_pass++;
      for (int h = 0; h < hold; h++) begin
        in_valid = $urandom_range(0, 1);
        data_i   = $urandom;
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b1 || data_o !== ey || in_ready !== 1'b0)
          $display("FAIL rnd_hold x=%0d: got ov=%b data=%0d ir=%b expected 1/%0d/0", x, out_valid, data_o, in_ready, ey);
        else n_pass++;
      end
      finish_op();
    end
  endtask

  task automatic test_backpressure();
    logic signed [31:0] x1, x2, e1, e2;
    logic c1, c2;
    int n1, n2, lat;
    x1 = 32'sd1000; x2 = -32'sd333;
    model(x1, e1, c1, n1);
    model(x2, e2, c2, n2);
    run_op(x1, lat);
    n_total++;
    if (data_o !== e1) $display("FAIL bp_first_data: got %0d expected %0d", data_o, e1);
    else n_pass++;
    in_valid = 1'b1;
    data_i   = x2;
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      n_total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || data_o !== e1)
        $display("FAIL bp_stall: got ov=%b ir=%b data=%0d expected 1/0/%0d", out_valid, in_ready, data_o, e1);
      else n_pass++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_idle: got ir=%b ov=%b expected 1/0", in_ready, out_valid);
    else n_pass++;
    // in_valid still high with x2: accepted on this edge.
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL bp_second_accept: got ir=%b expected 0", in_ready);
    else n_pass++;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    n_total++;
    if (lat !== n2 + 1 || data_o !== e2 || conv_o !== c2)
      $display("FAIL bp_second_result: got lat=%0d data=%0d conv=%b expected %0d/%0d/%b", lat, data_o, conv_o, n2 + 1, e2, c2);
    else n_pass++;
    finish_op();
  endtask

  task automatic test_reset_midop();
    int lat;
    in_valid = 1'b1;
    data_i   = 32'sd5000;
    @(posedge clk);
    @(negedge clk);           // BUSY cycle 1
    in_valid = 1'b0;
    @(negedge clk);           // BUSY cycle 2
    @(negedge clk);           // BUSY cycle 3
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || data_o !== 32'sd0 || conv_o !== 1'b0)
      $display("FAIL midreset_state: got ir=%b ov=%b data=%0d conv=%b expected 1/0/0/0", in_ready, out_valid, data_o, conv_o);
    else n_pass++;
    run_op(32'sd17, lat);
    n_total++;
    if (data_o !== 32'sd16 || conv_o !== 1'b1)
      $display("FAIL midreset_next: got data=%0d conv=%b expected 16/1", data_o, conv_o);
    else n_pass++;
    finish_op();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
